// File: rtl/kyber_pkg.sv
// Shared constants, legal compression widths and FSM encoding for the Kyber
// coefficient compress-and-pack block.
package kyber_pkg;

  localparam int unsigned KYBER_Q = 3329;
  localparam int unsigned KYBER_N = 256;

  // (x << D) + Q/2 for a 12-bit x and D up to 11 needs 23 bits.
  localparam int unsigned NUM_W  = 23;
  localparam int unsigned QUOT_W = 12;
  localparam int unsigned ACC_W  = 24;

  // Bit d set means compression width d is supported: {1, 4, 5, 10, 11}.
  localparam logic [15:0] LEGAL_D = 16'h0C32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } state_e;

  function automatic logic d_is_legal(logic [3:0] d);
    return LEGAL_D[d];
  endfunction

endpackage

// File: rtl/poly_compress_pack_if.sv
// Coefficient stream, byte stream and frame control for poly_compress_pack.
interface poly_compress_pack_if #(
  parameter int unsigned i_Width = 12
);

  logic               iStart;
  logic [3:0]         iD;
  logic               iCoeffValid;
  logic [i_Width-1:0] iPolyCoeffs;
  logic               oCoeffReady;
  logic               oByteValid;
  logic [7:0]         oByte;
  logic               oLast;
  logic               iByteReady;
  logic               oBusy;
  logic               oErr;

  modport slave (
    input  iStart, iD, iCoeffValid, iPolyCoeffs, iByteReady,
    output oCoeffReady, oByteValid, oByte, oLast, oBusy, oErr
  );

  modport master (
    output iStart, iD, iCoeffValid, iPolyCoeffs, iByteReady,
    input  oCoeffReady, oByteValid, oByte, oLast, oBusy, oErr
  );

endinterface

// File: rtl/poly_div_q.sv
// Registered exact floor(num / Modulus) using a constant reciprocal multiply
// followed by a single +1 correction step.
module poly_div_q
  import kyber_pkg::*;
#(
  parameter int unsigned Modulus = KYBER_Q
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [NUM_W-1:0]  num_i,
  output logic              valid_o,
  output logic [QUOT_W-1:0] quot_o
);

  // With a 2^32 scale the estimate undershoots by less than 2^-9 for a
  // 23-bit dividend, so it is either exact or one low.
  localparam int unsigned RecipShift = 32;
  localparam logic [63:0] Recip      = (64'd1 << RecipShift) / 64'(Modulus);

  logic [63:0] q_est;
  logic [63:0] rem;
  logic [63:0] quot;
  logic        valid_q;
  logic [QUOT_W-1:0] quot_q;

  always_comb begin
    q_est = (64'(num_i) * Recip) >> RecipShift;
    rem   = 64'(num_i) - q_est * 64'(Modulus);
    quot  = q_est + ((rem >= 64'(Modulus)) ? 64'd1 : 64'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      quot_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      quot_q  <= QUOT_W'(quot);
    end
  end

  assign valid_o = valid_q;
  assign quot_o  = quot_q;

endmodule

// File: rtl/poly_compress_pack.sv
// Compresses KYBER_N coefficients to D bits each and packs them LSB-first into
// a byte stream through a 3-stage pipeline and a 24-bit bit accumulator.
module poly_compress_pack #(
  parameter int unsigned KYBER_N = kyber_pkg::KYBER_N,
  parameter int unsigned KYBER_Q = kyber_pkg::KYBER_Q,
  parameter int unsigned i_Width = 12,
  parameter int unsigned D_MAX   = 11
) (
  input logic                 clk,
  input logic                 rst,
  poly_compress_pack_if.slave bus
);

  localparam int unsigned NumW     = kyber_pkg::NUM_W;
  localparam int unsigned QuotW    = kyber_pkg::QUOT_W;
  localparam int unsigned AccW     = kyber_pkg::ACC_W;
  localparam int unsigned CntW     = $clog2(KYBER_N);
  localparam int unsigned ByteCntW = $clog2(KYBER_N * D_MAX / 8 + 1);

  kyber_pkg::state_e state_q;
  logic [3:0]          d_q;
  logic [CntW-1:0]     coeff_cnt_q;
  logic [ByteCntW-1:0] byte_cnt_q;
  logic                err_q;

  logic            s1_valid_q;
  logic [NumW-1:0] s1_num_q;
  logic            s2_valid;
  logic [QuotW-1:0] s2_quot;

  logic [AccW-1:0] acc_q, acc_d, acc_shift;
  logic [4:0]      cnt_q, cnt_d, cnt_shift;

  logic             byte_valid, pop, stall, append, coeff_ready, accept, last_byte;
  logic [QuotW-1:0] coeff_mask, coeff_bits;
  logic [NumW-1:0]  num;
  logic [ByteCntW-1:0] byte_total;

  always_comb begin
    byte_valid = (cnt_q >= 5'd8);
    pop        = byte_valid && bus.iByteReady;
    acc_shift  = pop ? (acc_q >> 8) : acc_q;
    cnt_shift  = pop ? (cnt_q - 5'd8) : cnt_q;
    // Hold every stage while the pending code would overflow the accumulator.
    stall      = s2_valid && ((6'(cnt_shift) + 6'(d_q)) > 6'(AccW));
    append     = s2_valid && !stall;
    coeff_mask = (QuotW'(1) << d_q) - QuotW'(1);
    coeff_bits = s2_quot & coeff_mask;
    acc_d      = acc_shift;
    cnt_d      = cnt_shift;
    if (append) begin
      acc_d = acc_shift | (AccW'(coeff_bits) << cnt_shift);
      cnt_d = cnt_shift + 5'(d_q);
    end
    coeff_ready = (state_q == kyber_pkg::StRun) && !stall;
    accept      = coeff_ready && bus.iCoeffValid;
    num         = (NumW'(bus.iPolyCoeffs) << d_q) + NumW'(KYBER_Q / 2);
    byte_total  = ByteCntW'((KYBER_N * 32'(d_q)) / 8);
    last_byte   = byte_valid && (byte_cnt_q == byte_total - ByteCntW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= kyber_pkg::StIdle;
      d_q         <= '0;
      coeff_cnt_q <= '0;
      byte_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (pop) byte_cnt_q <= byte_cnt_q + ByteCntW'(1);
      case (state_q)
        kyber_pkg::StIdle: begin
          if (bus.iStart) begin
            if (kyber_pkg::d_is_legal(bus.iD)) begin
              d_q         <= bus.iD;
              coeff_cnt_q <= '0;
              byte_cnt_q  <= '0;
              state_q     <= kyber_pkg::StRun;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        kyber_pkg::StRun: begin
          if (accept) begin
            coeff_cnt_q <= coeff_cnt_q + CntW'(1);
            if (coeff_cnt_q == CntW'(KYBER_N - 1)) state_q <= kyber_pkg::StFlush;
          end
        end
        kyber_pkg::StFlush: begin
          if (pop && last_byte) state_q <= kyber_pkg::StIdle;
        end
        default: state_q <= kyber_pkg::StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_num_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      if (!stall) begin
        s1_valid_q <= accept;
        s1_num_q   <= num;
      end
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  poly_div_q #(
    .Modulus (KYBER_Q)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .en_i    (!stall),
    .valid_i (s1_valid_q),
    .num_i   (s1_num_q),
    .valid_o (s2_valid),
    .quot_o  (s2_quot)
  );

  assign bus.oCoeffReady = coeff_ready;
  assign bus.oByteValid  = byte_valid;
  assign bus.oByte       = acc_q[7:0];
  assign bus.oLast       = last_byte;
  assign bus.oBusy       = (state_q != kyber_pkg::StIdle);
  assign bus.oErr        = err_q;

endmodule

// File: tb/tb_poly_compress_pack.sv
// Bench for poly_compress_pack: golden compress+pack model, one byte-stream
// compare process, and directed frames with hand-computed byte values.
module tb_poly_compress_pack;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  poly_compress_pack_if #(.i_Width(12)) bus ();

  poly_compress_pack #(
    .KYBER_N (256),
    .KYBER_Q (3329),
    .i_Width (12),
    .D_MAX   (11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int applied     = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  int frame_total = 0;
  int frame_bytes = 0;
  int rdy_pct     = 100;
  int coeff[256];

  task automatic check(input string name, input int got, input int want);
    applied++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic int compress(input int x, input int d);
    return (((x << d) + 3329 / 2) / 3329) % (1 << d);
  endfunction

  task automatic model_pack(input int d);
    logic [7:0] bytes[352];
    int c, pos;
    for (int i = 0; i < 352; i++) bytes[i] = 8'h00;
    for (int k = 0; k < 256; k++) begin
      c = compress(coeff[k], d);
      for (int j = 0; j < d; j++) begin
        pos = k * d + j;
        bytes[pos / 8][pos % 8] = 1'((c >> j) & 1);
      end
    end
    for (int i = 0; i < 32 * d; i++) exp_q.push_back(bytes[i]);
  endtask

  task automatic pin_model(input string name, input int d, input logic [7:0] want);
    int bad = 0;
    foreach (exp_q[i]) if (exp_q[i] != want) bad++;
    check({name, "_model_bytes"}, bad, 0);
    check({name, "_model_len"}, exp_q.size(), 32 * d);
  endtask

  initial begin
    bus.iByteReady = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.iByteReady = ($urandom_range(99) < rdy_pct);
    end
  end

  // Byte-stream compare: content, oLast placement, and stability under stall.
  initial begin
    logic [7:0] held;
    logic [7:0] want;
    bit held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !bus.oByteValid) begin
        held_v = 1'b0;
      end else begin
        if (held_v) check("byte_hold", bus.oByte, held);
        if (bus.iByteReady) begin
          held_v = 1'b0;
          if (exp_q.size() == 0) begin
            applied++;
            miscompares++;
            $display("FAIL extra_byte: byte %0d got 0x%02h, expected none (frame of %0d)",
                     frame_bytes, bus.oByte, frame_total);
          end else begin
            want = exp_q.pop_front();
            check($sformatf("byte[%0d]", frame_bytes), bus.oByte, want);
            check($sformatf("last[%0d]", frame_bytes), bus.oLast,
                  int'(frame_bytes == frame_total - 1));
          end
          frame_bytes++;
        end else begin
          held   = bus.oByte;
          held_v = 1'b1;
        end
      end
    end
  end

  task automatic start_frame(input int d);
    @(posedge clk);
    #1;
    bus.iStart = 1'b1;
    bus.iD     = 4'(d);
    @(posedge clk);
    #1 bus.iStart = 1'b0;
  endtask

  task automatic send_coeffs(input int n, input int vpct);
    bit got;
    for (int k = 0; k < n; k++) begin
      while ($urandom_range(99) >= vpct) begin
        bus.iCoeffValid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.iCoeffValid = 1'b1;
      bus.iPolyCoeffs = 12'(coeff[k]);
      got = 1'b0;
      for (int t = 0; t < 2000 && !got; t++) begin
        @(negedge clk);
        got = bus.oCoeffReady;
        @(posedge clk);
        #1;
      end
      if (!got) begin
        applied++;
        miscompares++;
        $display("FAIL coeff_accept: coefficient %0d not accepted, ready stuck at 0, expected 1",
                 k);
        bus.iCoeffValid = 1'b0;
        return;
      end
    end
    bus.iCoeffValid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.oBusy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("frame_done", bus.oBusy, 0);
  endtask

  task automatic run_frame(input int d, input int vpct, input int rpct, input bit poke_start);
    rdy_pct     = rpct;
    frame_total = 32 * d;
    frame_bytes = 0;
    start_frame(d);
    if (poke_start) begin
      bus.iStart = 1'b1;
      bus.iD     = 4'd4;
      @(posedge clk);
      #1 bus.iStart = 1'b0;
    end
    send_coeffs(256, vpct);
    wait_idle();
    check($sformatf("frame_bytes_d%0d", d), frame_bytes, 32 * d);
    check($sformatf("leftover_d%0d", d), exp_q.size(), 0);
    check("drained_valid", bus.oByteValid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, bus.oCoeffReady, 0);
    check({tag, "_bvalid"}, bus.oByteValid, 0);
    check({tag, "_byte"}, bus.oByte, 0);
    check({tag, "_last"}, bus.oLast, 0);
    check({tag, "_busy"}, bus.oBusy, 0);
    check({tag, "_err"}, bus.oErr, 0);
  endtask

  initial begin
    bus.iStart      = 1'b0;
    bus.iD          = 4'd0;
    bus.iCoeffValid = 1'b0;
    bus.iPolyCoeffs = 12'd0;
    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed compress values.
    check("c_d1_832", compress(832, 1), 0);
    check("c_d1_833", compress(833, 1), 1);
    check("c_d1_2496", compress(2496, 1), 1);
    check("c_d1_2497", compress(2497, 1), 0);
    check("c_d4_1000", compress(1000, 4), 5);
    check("c_d10_3328", compress(3328, 10), 0);
    check("c_d11_0", compress(0, 11), 0);

    // D=1 boundary pattern: codes 0,1,1,0 per nibble -> 0x66.
    for (int k = 0; k < 256; k++) begin
      case (k % 4)
        0: coeff[k] = 832;
        1: coeff[k] = 833;
        2: coeff[k] = 2496;
        default: coeff[k] = 2497;
      endcase
    end
    exp_q.delete();
    model_pack(1);
    pin_model("d1_edges", 1, 8'h66);
    run_frame(1, 100, 100, 1'b0);

    for (int k = 0; k < 256; k++) coeff[k] = 833;
    exp_q.delete();
    model_pack(1);
    pin_model("d1_833", 1, 8'hFF);
    run_frame(1, 100, 40, 1'b0);

    for (int k = 0; k < 256; k++) coeff[k] = 1000;
    exp_q.delete();
    model_pack(4);
    pin_model("d4_1000", 4, 8'h55);
    run_frame(4, 60, 100, 1'b0);

    for (int k = 0; k < 256; k++) coeff[k] = 3328;
    exp_q.delete();
    model_pack(10);
    pin_model("d10_3328", 10, 8'h00);
    run_frame(10, 100, 30, 1'b0);

    for (int k = 0; k < 256; k++) coeff[k] = 0;
    exp_q.delete();
    model_pack(11);
    pin_model("d11_zero", 11, 8'h00);
    run_frame(11, 100, 100, 1'b0);

    // Illegal width: one-cycle error, no frame.
    exp_q.delete();
    frame_total = 0;
    frame_bytes = 0;
    start_frame(3);
    @(negedge clk);
    check("err_pulse", bus.oErr, 1);
    check("err_busy", bus.oBusy, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("err_after", bus.oErr, 0);
      check("err_busy_after", bus.oBusy, 0);
      check("err_no_bytes", bus.oByteValid, 0);
    end

    // Random D=11 under bubbles and backpressure, with a stray iStart mid-frame.
    for (int k = 0; k < 256; k++) coeff[k] = int'($urandom_range(4095));
    exp_q.delete();
    model_pack(11);
    run_frame(11, 70, 50, 1'b1);

    // Abort a D=5 frame after 100 coefficients.
    for (int k = 0; k < 256; k++) coeff[k] = int'($urandom_range(3328));
    exp_q.delete();
    model_pack(5);
    rdy_pct     = 60;
    frame_total = 160;
    frame_bytes = 0;
    start_frame(5);
    send_coeffs(100, 80);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 256; k++) coeff[k] = int'($urandom_range(4095));
    model_pack(5);
    run_frame(5, 80, 70, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/poly_compress_pack.md
POLY_COMPRESS_PACK -- requirements
Module: poly_compress_pack

Interface
REQ-001 SHALL have parameter KYBER_N, default 256, meaning coefficients per polynomial.
REQ-002 SHALL have parameter KYBER_Q, default 3329, meaning modulus.
REQ-003 SHALL have parameter i_Width, default 12, meaning input coefficient width.
REQ-004 SHALL have parameter D_MAX, default 11, meaning largest supported compression width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port iStart, input, 1 bit: frame start pulse, accepted only in IDLE.
REQ-008 SHALL have port iD, input, 4 bits: compression width, sampled on an accepted iStart.
REQ-009 SHALL have ports iCoeffValid (input, 1), iPolyCoeffs (input, i_Width) and oCoeffReady (output, 1), forming the coefficient stream.
REQ-010 SHALL have ports oByteValid (output, 1), oByte (output, 8), oLast (output, 1) and iByteReady (input, 1), forming the byte stream.
REQ-011 SHALL have ports oBusy (output, 1), high when not IDLE, and oErr (output, 1), a one-cycle illegal-mode pulse.

Function
REQ-012 SHALL compute per coefficient x: c = floor(((x << D) + floor(KYBER_Q/2)) / KYBER_Q) mod 2^D, exact for all x < 2^i_Width; the numerator SHALL be 23 bits wide, with no truncation.
REQ-013 SHALL accept D in {1,4,5,10,11}; any other iD with iStart SHALL pulse oErr for one cycle and remain in IDLE.
REQ-014 SHALL implement states IDLE, RUN and FLUSH: IDLE->RUN on a legal iStart; RUN->FLUSH when the KYBER_N-th coefficient is accepted; FLUSH->IDLE when the last byte handshakes.
REQ-015 SHALL transfer a coefficient only when iCoeffValid and oCoeffReady are both high; oCoeffReady SHALL be low in IDLE and FLUSH.
REQ-016 SHALL use a 3-stage datapath: stage 1 forms the numerator, stage 2 divides by Q, stage 3 masks and appends into the bit accumulator; an accepted coefficient SHALL update the accumulator exactly 3 cycles later when there is no stall.
REQ-017 SHALL use a 24-bit LSB-first accumulator: bit j of coefficient k goes to stream bit k*D+j, and byte i carries stream bits 8i..8i+7.
REQ-018 SHALL hold oByteValid high whenever the accumulator holds at least 8 bits; the byte SHALL leave on oByteValid and iByteReady, and oByte SHALL stay stable while stalled.
REQ-019 SHALL allow a byte pop and a coefficient append in the same cycle.
REQ-020 SHALL stall the whole pipeline (oCoeffReady low, stages hold) whenever stage 3 could not append D bits without exceeding 24 bits after a same-cycle pop; no bit may be lost or duplicated.
REQ-021 SHALL emit exactly 32*D bytes per frame, with oLast high only on the final byte.
REQ-022 SHALL ignore iStart outside IDLE.
REQ-023 SHALL treat gaps in iCoeffValid as bubbles, with no effect on output content.

Reset
REQ-024 SHALL, on rst, asynchronously force: state IDLE; accumulator, bit count, coefficient counter and pipeline valids to 0; oCoeffReady, oByteValid, oLast, oBusy and oErr to 0; oByte to 0x00.
REQ-025 SHALL, on rst mid-frame, discard all partial data; the next frame SHALL be unaffected.

Structure
REQ-026 SHALL place KYBER_Q, KYBER_N, the legal-D list, the 23-bit numerator width and the state encoding in shared package kyber_pkg.
REQ-027 SHALL implement the divide-by-Q stage as the sub-module poly_div_q: registered, 1-cycle latency, with a stall enable, exact floor division of a 23-bit dividend by KYBER_Q via constant-reciprocal multiply and correction.

Verification
REQ-028 SHALL be checked with D=1 and x = 832, 833, 2496, 2497, giving c = 0, 1, 1, 0.
REQ-029 SHALL be checked with D=4, x=1000 -> c=5; D=10, x=3328 -> c=0 (1024 wraps); D=11, x=0 -> c=0.
REQ-030 SHALL be checked with D=1 and 256 x 833: exactly 32 bytes of 0xFF, and oLast on byte 32 only.
REQ-031 SHALL be checked with D=11, random coefficients and random iByteReady and iCoeffValid: 352 bytes matching a golden compress+pack model, with no loss under stalls.
REQ-032 SHALL be checked with iStart and iD=3: a 1-cycle oErr, oBusy stays 0, and no bytes are emitted.
REQ-033 SHALL be checked with rst asserted after 100 coefficients at D=5: all outputs 0 immediately, and the next D=5 frame produces 160 correct bytes.
